// File: rtl/csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
//   num_stages()   : number of carry-resolution stages (ceil division)
//   params_legal() : elaboration-time legality of the parameter set
//   stage_ctl_t    : control part of a pipeline stage register.
//                    The data part (partial sum, remaining a/b) depends on
//                    WIDTH, so the top level wraps this struct with those
//                    fields.
package csel_adder_pkg;

    typedef struct packed {
        logic valid;  // stage holds a live operation
        logic carry;  // carry out of the highest block resolved so far
        logic c_msb;  // carry into the MSB of the highest resolved block
    } stage_ctl_t;

    function automatic int num_stages(input int width, input int block_w, input int bps);
        return ((width / block_w) + bps - 1) / bps;
    endfunction

    function automatic bit params_legal(input int width, input int block_w, input int bps);
        return (width >= 4) && (block_w >= 2) && (bps >= 1) && ((width % block_w) == 0);
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two ripple chains (carry-in 0 and 1) computed in
// parallel, with the real block carry-in picking the result.
//   a, b  : block operands
//   cin   : incoming block carry (select)
//   sum   : selected block sum
//   cout  : carry out of the block MSB
//   c_msb : carry into the block MSB (used for signed overflow)
module csel_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [BLOCK_W:0]   c0;
    logic [BLOCK_W:0]   c1;
    logic [BLOCK_W-1:0] s0;
    logic [BLOCK_W-1:0] s1;

    always_comb begin
        c0 = '0;
        c1 = '0;
        s0 = '0;
        s1 = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLOCK_W; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum   = cin ? s1 : s0;
    assign cout  = cin ? c1[BLOCK_W] : c0[BLOCK_W];
    assign c_msb = cin ? c1[BLOCK_W-1] : c0[BLOCK_W-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Stage 0 registers the operands (b and cin pre-inverted for subtract);
// each following stage resolves BLOCKS_PER_STAGE carry-select blocks and
// passes the partial sum, the resolved carry and the still-unused operand
// bits onward. The whole pipe freezes while the output is held.
//   clk, reset           : clock, async active-high reset
//   in_valid / in_ready  : operand handshake
//   a, b, cin, sub       : operands; sub=1 computes a-b-cin
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry-out (no-borrow for sub), signed ovf
module csel_adder_pipe
    import csel_adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int BLOCK_W          = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_W;
    localparam int NUM_STAGES = num_stages(WIDTH, BLOCK_W, BLOCKS_PER_STAGE);

    if (!params_legal(WIDTH, BLOCK_W, BLOCKS_PER_STAGE)) begin : g_param_check
        $error("csel_adder_pipe: illegal parameters WIDTH=%0d BLOCK_W=%0d BLOCKS_PER_STAGE=%0d",
               WIDTH, BLOCK_W, BLOCKS_PER_STAGE);
    end

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t st  [0:NUM_STAGES];
    stage_t nxt [1:NUM_STAGES];

    logic [WIDTH-1:0]      res_sum;
    logic [NUM_BLOCKS-1:0] res_cout;
    logic [NUM_BLOCKS-1:0] res_cmsb;
    logic                  stall;

    assign stall     = st[NUM_STAGES].ctl.valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = st[NUM_STAGES].ctl.valid;
    assign sum       = st[NUM_STAGES].sum;
    assign cout      = st[NUM_STAGES].ctl.carry;
    assign ovf       = st[NUM_STAGES].ctl.c_msb ^ st[NUM_STAGES].ctl.carry;

    // Block j is resolved by stage j/BLOCKS_PER_STAGE+1 from register
    // st[j/BLOCKS_PER_STAGE]. The first block of a stage takes the registered
    // carry; the others chain combinationally off their neighbour.
    for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_blk
        localparam int SRC = j / BLOCKS_PER_STAGE;
        logic               blk_cin;
        logic               blk_cout;
        logic               blk_cmsb;
        logic [BLOCK_W-1:0] blk_sum;

        if ((j % BLOCKS_PER_STAGE) == 0) begin : g_first
            assign blk_cin = st[SRC].ctl.carry;
        end else begin : g_chain
            assign blk_cin = g_blk[j-1].blk_cout;
        end

        csel_block #(.BLOCK_W(BLOCK_W)) u_blk (
            .a     (st[SRC].a[j*BLOCK_W +: BLOCK_W]),
            .b     (st[SRC].b[j*BLOCK_W +: BLOCK_W]),
            .cin   (blk_cin),
            .sum   (blk_sum),
            .cout  (blk_cout),
            .c_msb (blk_cmsb)
        );

        assign res_sum[j*BLOCK_W +: BLOCK_W] = blk_sum;
        assign res_cout[j]                   = blk_cout;
        assign res_cmsb[j]                   = blk_cmsb;
    end

    // Blocks are visited in ascending order, so the last block of each stage
    // leaves its carry (and MSB carry-in) in that stage's control fields.
    always_comb begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
            nxt[k] = st[k-1];
        end
        for (int j = 0; j < NUM_BLOCKS; j++) begin
            nxt[j / BLOCKS_PER_STAGE + 1].sum[j*BLOCK_W +: BLOCK_W] = res_sum[j*BLOCK_W +: BLOCK_W];
            nxt[j / BLOCKS_PER_STAGE + 1].ctl.carry = res_cout[j];
            nxt[j / BLOCKS_PER_STAGE + 1].ctl.c_msb = res_cmsb[j];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                st[k] <= '0;
            end
        end else if (!stall) begin
            st[0].ctl.valid <= in_valid;
            st[0].ctl.carry <= cin ^ sub;
            st[0].ctl.c_msb <= 1'b0;
            st[0].sum       <= '0;
            st[0].a         <= a;
            st[0].b         <= b ^ {WIDTH{sub}};
            for (int k = 1; k <= NUM_STAGES; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
module tb_csel_adder_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    int          sel;

    logic        ir16, ov16, c16, f16;
    logic [15:0] s16;
    logic        ir8, ov8, c8, f8;
    logic [7:0]  s8;
    logic        ir32, ov32, c32, f32;
    logic [31:0] s32;

    logic        obs_valid, obs_in_ready, obs_cout, obs_ovf;
    logic [31:0] obs_sum;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    csel_adder_pipe dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir16),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(c16), .ovf(f16)
    );

    csel_adder_pipe #(.WIDTH(8), .BLOCK_W(8), .BLOCKS_PER_STAGE(2)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(c8), .ovf(f8)
    );

    csel_adder_pipe #(.WIDTH(32), .BLOCK_W(4), .BLOCKS_PER_STAGE(3)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32),
        .a(a_drv), .b(b_drv), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(c32), .ovf(f32)
    );

    always_comb begin
        obs_valid    = ov16;
        obs_in_ready = ir16;
        obs_sum      = {16'd0, s16};
        obs_cout     = c16;
        obs_ovf      = f16;
        if (sel == 1) begin
            obs_valid    = ov8;
            obs_in_ready = ir8;
            obs_sum      = {24'd0, s8};
            obs_cout     = c8;
            obs_ovf      = f8;
        end else if (sel == 2) begin
            obs_valid    = ov32;
            obs_in_ready = ir32;
            obs_sum      = s32;
            obs_cout     = c32;
            obs_ovf      = f32;
        end
    end

    // Reference: {cout, ovf, sum}; overflow from operand/result signs.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [32:0] full;
        logic [31:0] m, xx, yy, r;
        logic        co, ov;
        m    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        xx   = x & m;
        yy   = (s ? ~y : y) & m;
        full = {1'b0, xx} + {1'b0, yy} + {32'd0, c ^ s};
        r    = full[31:0] & m;
        co   = full[w];
        ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        return {co, ov, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic single(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input logic ts, output int lat, output logic [33:0] res);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_drv     = ta;
        b_drv     = tb;
        cin       = tc;
        sub       = ts;
        #1 chk("single_in_ready", obs_in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!obs_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {obs_cout, obs_ovf, obs_sum};
    endtask

    task automatic stream(input string tag, input int w, input int n, input int exhaustive,
                          input int stall_lo, input int stall_hi, input int check_contig);
        logic [33:0] q[$];
        logic [31:0] va, vb;
        logic        vc, vs;
        int sent = 0, rcvd = 0, cyc = 0, first = -1, last = -1;
        while ((sent < n || rcvd < sent) && cyc < n + 200) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (sent < n) begin
                if (exhaustive != 0) begin
                    va = 32'(sent % 256);
                    vb = 32'(sent / 256);
                end else begin
                    va = $urandom;
                    vb = $urandom;
                end
                vc       = 1'($urandom_range(0, 1));
                vs       = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                a_drv    = va;
                b_drv    = vb;
                cin      = vc;
                sub      = vs;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (obs_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious"}, 1, 0);
                end else begin
                    chk(tag, {obs_cout, obs_ovf, obs_sum}, q[0]);
                    void'(q.pop_front());
                end
                rcvd++;
                if (first < 0) first = cyc;
                last = cyc;
            end else if (obs_valid) begin
                chk({tag, "_stall_in_ready"}, obs_in_ready, 0);
                if (q.size() != 0) chk({tag, "_held"}, {obs_cout, obs_ovf, obs_sum}, q[0]);
            end
            if (in_valid && obs_in_ready) begin
                q.push_back(model(w, va, vb, vc, vs));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, rcvd, n);
        if (check_contig != 0) chk({tag, "_contiguous"}, last - first, n - 1);
    endtask

    int          lat;
    logic [33:0] res;
    int          spurious;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cin       = 1'b0;
        sub       = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        sel       = 0;

        #1;
        chk("rst_out_valid", ov16, 0);
        chk("rst_sum", s16, 0);
        chk("rst_cout_ovf", {c16, f16}, 0);
        chk("rst_in_ready", ir16, 1);
        chk("rst_valid_8_32", {ov8, ov32}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed 16-bit vectors, hand-computed {cout, ovf, sum}
        single(32'hFFFF, 32'h0001, 0, 0, lat, res);
        chk("add_wrap_latency", lat, 3);
        chk("add_wrap", res, {1'b1, 1'b0, 32'h0000});
        single(32'h7FFF, 32'h0001, 0, 0, lat, res);
        chk("add_ovf_pos", res, {1'b0, 1'b1, 32'h8000});
        single(32'h8000, 32'h8000, 0, 0, lat, res);
        chk("add_ovf_neg", res, {1'b1, 1'b1, 32'h0000});
        single(32'h00FF, 32'h0F00, 1, 0, lat, res);
        chk("add_cin", res, {1'b0, 1'b0, 32'h1000});
        single(32'h0005, 32'h0007, 0, 1, lat, res);
        chk("sub_borrow", res, {1'b0, 1'b0, 32'hFFFE});
        single(32'h8000, 32'h0001, 0, 1, lat, res);
        chk("sub_ovf", res, {1'b1, 1'b1, 32'h7FFF});
        single(32'h0010, 32'h0001, 1, 1, lat, res);
        chk("sub_cin", res, {1'b1, 1'b0, 32'h000E});

        // Throughput, then backpressure mid-stream
        stream("burst16", 16, 8, 0, -1, -1, 1);
        stream("bp16", 16, 12, 0, 5, 8, 0);

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_drv    = 32'h1111 * (i + 1);
            b_drv    = 32'h0101;
            cin      = 1'b0;
            sub      = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("inflight_valid", ov16, 1);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", ov16, 0);
        chk("midrst_sum", s16, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("postrst_in_ready", ir16, 1);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov16) spurious++;
        end
        chk("postrst_no_stale", spurious, 0);
        single(32'h1234, 32'h4321, 1, 0, lat, res);
        chk("postrst_latency", lat, 3);
        chk("postrst_result", res, {1'b0, 1'b0, 32'h5556});

        // WIDTH=8, single block: LATENCY=2
        sel = 1;
        single(32'h00FF, 32'h0001, 0, 0, lat, res);
        chk("w8_latency", lat, 2);
        chk("w8_wrap", res, {1'b1, 1'b0, 32'h00});
        single(32'h0080, 32'h0001, 0, 1, lat, res);
        chk("w8_sub_ovf", res, {1'b1, 1'b1, 32'h7F});
        stream("exh8", 8, 65536, 1, -1, -1, 1);

        // WIDTH=32, 8 blocks of 4, 3 per stage: LATENCY=4
        sel = 2;
        single(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, lat, res);
        chk("w32_latency", lat, 4);
        chk("w32_wrap", res, {1'b1, 1'b0, 32'h0000_0000});
        single(32'h8000_0000, 32'h0000_0001, 0, 1, lat, res);
        chk("w32_sub_ovf", res, {1'b1, 1'b1, 32'h7FFF_FFFF});
        stream("rnd32", 32, 300, 0, -1, -1, 1);
        stream("bp32", 32, 40, 0, 10, 14, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
